pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the iCE40 PLL active-low reset from the raw
// reference clock. It qualifies the asynchronous PLL LOCK and releases the
// system reset only after lock has been continuously stable. A lock loss
// re-sequences the PLL, and a missing lock is retried automatically.
//
// Ports:
//   REFERENCECLK  in   reference clock, the only clock of this block
//   RESET         in   synchronous active-low reset
//   LOCK          in   PLL lock, asynchronous to REFERENCECLK
//   PLL_RESETB    out  active-low reset to the PLL RESETB pin
//   SYS_RESETN    out  active-low system reset, high only in RUN
//   READY         out  high only in RUN, mirrors SYS_RESETN
//   RETRY_CNT     out  saturating count of lock-timeout retries
//   RELOCK_CNT    out  saturating count of lock losses seen in RUN
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 12000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1200
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       LOCK,
    output logic       PLL_RESETB,
    output logic       SYS_RESETN,
    output logic       READY,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] RELOCK_CNT
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_PLLRST   = 4'b0001,
        S_WAITLOCK = 4'b0010,
        S_STABLE   = 4'b0100,
        S_RUN      = 4'b1000
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              lock_meta;
    logic              lock_s;
    logic              retry_inc;
    logic              relock_inc;
    logic              pll_resetb_d;
    logic              sys_resetn_d;

    // Two-flop synchronizer for the asynchronous LOCK
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCK;
            lock_s    <= lock_meta;
        end
    end

    // State register and shared cycle counter (cleared on every state change)
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            state <= S_PLLRST;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else if (state != S_RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic; lock takes priority over the timeout in WAITLOCK
    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        relock_inc = 1'b0;
        unique case (state)
            S_PLLRST: begin
                if (cnt == RST_LAST) begin
                    next_state = S_WAITLOCK;
                end
            end
            S_WAITLOCK: begin
                if (lock_s) begin
                    next_state = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = S_PLLRST;
                    retry_inc  = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    next_state = S_WAITLOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    next_state = S_PLLRST;
                    relock_inc = 1'b1;
                end
            end
            default: begin
                next_state = S_PLLRST;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track state
    always_comb begin
        pll_resetb_d = 1'b1;
        sys_resetn_d = 1'b0;
        if (next_state == S_PLLRST) begin
            pll_resetb_d = 1'b0;
        end
        if (next_state == S_RUN) begin
            sys_resetn_d = 1'b1;
        end
    end

    // Registered outputs and saturating event counters
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            PLL_RESETB <= 1'b0;
            SYS_RESETN <= 1'b0;
            READY      <= 1'b0;
            RETRY_CNT  <= '0;
            RELOCK_CNT <= '0;
        end else begin
            PLL_RESETB <= pll_resetb_d;
            SYS_RESETN <= sys_resetn_d;
            READY      <= sys_resetn_d;
            if (retry_inc && (RETRY_CNT != 4'hF)) begin
                RETRY_CNT <= RETRY_CNT + 4'd1;
            end
            if (relock_inc && (RELOCK_CNT != 8'hFF)) begin
                RELOCK_CNT <= RELOCK_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       RESET;
    logic       LOCK;
    logic       PLL_RESETB;
    logic       SYS_RESETN;
    logic       READY;
    logic [3:0] RETRY_CNT;
    logic [7:0] RELOCK_CNT;

    int errors = 0;
    int checks = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (20),
        .LOCK_STABLE_CYCLES (8)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (RESET),
        .LOCK         (LOCK),
        .PLL_RESETB   (PLL_RESETB),
        .SYS_RESETN   (SYS_RESETN),
        .READY        (READY),
        .RETRY_CNT    (RETRY_CNT),
        .RELOCK_CNT   (RELOCK_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges; outputs are looked at 1 time unit after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        int exp_pll;
        int exp_retry;
        int exp_relock;

        RESET = 1'b0;
        LOCK  = 1'b0;
        tick(3);
        chk("rst_pll_resetb", 8'(PLL_RESETB), 8'd0);
        chk("rst_sys_resetn", 8'(SYS_RESETN), 8'd0);
        chk("rst_ready",      8'(READY),      8'd0);
        chk("rst_retry",      8'(RETRY_CNT),  8'd0);
        chk("rst_relock",     RELOCK_CNT,     8'd0);

        // Clean power-up lock
        RESET = 1'b1;
        tick(3);
        chk("rel_pll_low_e3", 8'(PLL_RESETB), 8'd0);
        tick(1);
        chk("rel_pll_high_e4", 8'(PLL_RESETB), 8'd1);
        tick(4);
        LOCK = 1'b1;
        tick(10);
        chk("acq_sys_e10",   8'(SYS_RESETN), 8'd0);
        chk("acq_ready_e10", 8'(READY),      8'd0);
        tick(1);
        chk("acq_sys_e11",   8'(SYS_RESETN), 8'd1);
        chk("acq_ready_e11", 8'(READY),      8'd1);
        chk("acq_pll_e11",   8'(PLL_RESETB), 8'd1);
        chk("acq_retry",     8'(RETRY_CNT),  8'd0);
        chk("acq_relock",    RELOCK_CNT,     8'd0);

        // Lock loss in RUN and full re-sequence
        LOCK = 1'b0;
        tick(2);
        chk("loss_sys_e2", 8'(SYS_RESETN), 8'd1);
        chk("loss_pll_e2", 8'(PLL_RESETB), 8'd1);
        tick(1);
        chk("loss_sys_e3",   8'(SYS_RESETN), 8'd0);
        chk("loss_ready_e3", 8'(READY),      8'd0);
        chk("loss_pll_e3",   8'(PLL_RESETB), 8'd0);
        chk("loss_relock",   RELOCK_CNT,     8'd1);
        tick(3);
        chk("reseq_pll_low", 8'(PLL_RESETB), 8'd0);
        tick(1);
        chk("reseq_pll_high", 8'(PLL_RESETB), 8'd1);
        LOCK = 1'b1;
        tick(10);
        chk("reseq_sys_e10", 8'(SYS_RESETN), 8'd0);
        tick(1);
        chk("reseq_sys_e11", 8'(SYS_RESETN), 8'd1);

        // Second loss, then a 2-cycle LOCK glitch during qualification
        LOCK = 1'b0;
        tick(7);
        chk("glitch_relock",  RELOCK_CNT,     8'd2);
        chk("glitch_pll_hi",  8'(PLL_RESETB), 8'd1);
        LOCK = 1'b1;
        tick(7);
        LOCK = 1'b0;
        tick(2);
        LOCK = 1'b1;
        tick(10);
        chk("glitch_sys_e10", 8'(SYS_RESETN), 8'd0);
        tick(1);
        chk("glitch_sys_e11", 8'(SYS_RESETN), 8'd1);
        chk("glitch_retry",   8'(RETRY_CNT),  8'd0);

        // Third loss so RELOCK_CNT reaches 3 in RUN
        LOCK = 1'b0;
        tick(7);
        LOCK = 1'b1;
        tick(11);
        chk("run3_ready",  8'(READY),  8'd1);
        chk("run3_relock", RELOCK_CNT, 8'd3);

        // One-cycle reset while in RUN
        RESET = 1'b0;
        tick(1);
        chk("midrst_pll",    8'(PLL_RESETB), 8'd0);
        chk("midrst_sys",    8'(SYS_RESETN), 8'd0);
        chk("midrst_ready",  8'(READY),      8'd0);
        chk("midrst_retry",  8'(RETRY_CNT),  8'd0);
        chk("midrst_relock", RELOCK_CNT,     8'd0);
        RESET = 1'b1;
        tick(3);
        chk("midrst_pll_e3", 8'(PLL_RESETB), 8'd0);
        tick(1);
        chk("midrst_pll_e4", 8'(PLL_RESETB), 8'd1);
        tick(8);
        chk("midrst_sys_e12", 8'(SYS_RESETN), 8'd0);
        tick(1);
        chk("midrst_sys_e13", 8'(SYS_RESETN), 8'd1);

        // Lock sync arrives on the same edge the timeout would fire
        RESET = 1'b0;
        LOCK  = 1'b0;
        tick(2);
        RESET = 1'b1;
        tick(21);
        LOCK = 1'b1;
        tick(3);
        chk("simul_pll",   8'(PLL_RESETB), 8'd1);
        chk("simul_retry", 8'(RETRY_CNT),  8'd0);
        tick(7);
        chk("simul_sys_e31", 8'(SYS_RESETN), 8'd0);
        tick(1);
        chk("simul_sys_e32", 8'(SYS_RESETN), 8'd1);

        // Timeout retries with LOCK held low, past RETRY_CNT saturation
        RESET = 1'b0;
        LOCK  = 1'b0;
        tick(2);
        chk("to_rst_retry", 8'(RETRY_CNT), 8'd0);
        RESET = 1'b1;
        for (int n = 1; n <= 17 * 24; n++) begin
            tick(1);
            exp_pll   = ((n % 24) < 4) ? 0 : 1;
            exp_retry = ((n / 24) > 15) ? 15 : (n / 24);
            chk("to_pll",   8'(PLL_RESETB), 8'(exp_pll));
            chk("to_retry", 8'(RETRY_CNT),  8'(exp_retry));
            chk("to_sys",   8'(SYS_RESETN), 8'd0);
        end

        // RELOCK_CNT saturation over repeated lock losses
        RESET = 1'b0;
        tick(1);
        RESET = 1'b1;
        LOCK  = 1'b1;
        tick(13);
        chk("sat_run_ready", 8'(READY), 8'd1);
        for (int i = 1; i <= 257; i++) begin
            LOCK = 1'b0;
            tick(7);
            exp_relock = (i > 255) ? 255 : i;
            chk("sat_relock", RELOCK_CNT, 8'(exp_relock));
            LOCK = 1'b1;
            tick(11);
            chk("sat_ready", 8'(READY), 8'd1);
        end
        chk("sat_retry", 8'(RETRY_CNT), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
